// File: rtl/conv_ag_pkg.sv
// Shared types and constants for the convolution window address generator.
// The config struct is sized from these constants; the top-level parameters default to them.
package conv_ag_pkg;

  localparam int PKG_BUF_DEPTH = 1024;
  localparam int PKG_DIM_WIDTH = 8;
  localparam int PKG_CH_WIDTH  = 6;
  localparam int PKG_ADDR_WIDTH = $clog2(PKG_BUF_DEPTH);

  // Signed width for tap coordinates: o*S needs 2*DIM bits, +kx and -P need headroom and a sign.
  localparam int TAP_SW = PKG_DIM_WIDTH * 2 + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [PKG_DIM_WIDTH-1:0]  k_size;
    logic [PKG_DIM_WIDTH-1:0]  i_size;
    logic [PKG_CH_WIDTH-1:0]   ch;
    logic [PKG_DIM_WIDTH-1:0]  stride;
    logic [PKG_DIM_WIDTH-1:0]  pad;
    logic [PKG_DIM_WIDTH-1:0]  o_x;
    logic [PKG_DIM_WIDTH-1:0]  o_y;
    logic [PKG_ADDR_WIDTH-1:0] start_addr;
    logic [PKG_ADDR_WIDTH-1:0] ch_stride;
  } cfg_t;

endpackage

// File: rtl/conv_tap_addr_calc.sv
// Combinational tap address: maps (c, kx, ky) under a window config to an
// input-buffer address, or flags the tap as lying in the zero-padding border.
module conv_tap_addr_calc
  import conv_ag_pkg::*;
(
  input  cfg_t                      cfg,
  input  logic [PKG_CH_WIDTH-1:0]   c,
  input  logic [PKG_DIM_WIDTH-1:0]  kx,
  input  logic [PKG_DIM_WIDTH-1:0]  ky,
  output logic [PKG_ADDR_WIDTH-1:0] addr,
  output logic                      pad
);

  logic signed [TAP_SW-1:0] r;
  logic signed [TAP_SW-1:0] col;
  logic signed [TAP_SW-1:0] w;
  logic [31:0]              lin;

  // NOTE: every signal written here is assigned unconditionally, so no latch is inferred.
  always_comb begin
    r   = signed'(TAP_SW'(cfg.o_x) * TAP_SW'(cfg.stride) + TAP_SW'(kx)) - signed'(TAP_SW'(cfg.pad));
    col = signed'(TAP_SW'(cfg.o_y) * TAP_SW'(cfg.stride) + TAP_SW'(ky)) - signed'(TAP_SW'(cfg.pad));
    w   = signed'(TAP_SW'(cfg.i_size));
    pad = r[TAP_SW-1] | col[TAP_SW-1] | (r >= w) | (col >= w);
    // Only meaningful for in-plane taps, where r and col are non-negative.
    lin = 32'(cfg.start_addr)
        + 32'(c) * 32'(cfg.ch_stride)
        + 32'(r[TAP_SW-1:0]) * 32'(cfg.i_size)
        + 32'(col[TAP_SW-1:0]);
    addr = pad ? '0 : PKG_ADDR_WIDTH'(lin % 32'(PKG_BUF_DEPTH));
  end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Convolution window address generator: walks channel, kernel row, kernel column
// for one output pixel and streams one input-buffer address per tap with valid/ready.
module conv_window_addr_gen
  import conv_ag_pkg::*;
#(
  parameter  int BUF_DEPTH  = PKG_BUF_DEPTH,
  parameter  int DIM_WIDTH  = PKG_DIM_WIDTH,
  parameter  int CH_WIDTH   = PKG_CH_WIDTH,
  localparam int ADDR_WIDTH = $clog2(BUF_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic                  i_clear,
  input  logic [DIM_WIDTH-1:0]  i_k_size,
  input  logic [DIM_WIDTH-1:0]  i_i_size,
  input  logic [CH_WIDTH-1:0]   i_ch,
  input  logic [DIM_WIDTH-1:0]  i_stride,
  input  logic [DIM_WIDTH-1:0]  i_pad,
  input  logic [DIM_WIDTH-1:0]  i_o_x,
  input  logic [DIM_WIDTH-1:0]  i_o_y,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_ch_stride,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_pad,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cfg_err
);

  state_e state_q, state_d;
  cfg_t   cfg_in, cfg_q, sel_cfg;

  logic [PKG_CH_WIDTH-1:0]  c_q, c_n, sel_c;
  logic [PKG_DIM_WIDTH-1:0] kx_q, kx_n, ky_q, ky_n, sel_kx, sel_ky;
  logic [PKG_DIM_WIDTH-1:0] k_m1;
  logic                     cfg_bad, accept, hs, at_last, sel_last;
  logic [PKG_ADDR_WIDTH-1:0] calc_addr;
  logic                     calc_pad;

  assign cfg_in = '{
    k_size:     i_k_size,
    i_size:     i_i_size,
    ch:         i_ch,
    stride:     i_stride,
    pad:        i_pad,
    o_x:        i_o_x,
    o_y:        i_o_y,
    start_addr: i_start_addr,
    ch_stride:  i_ch_stride
  };

  assign cfg_bad = (cfg_in.k_size == '0) || (cfg_in.ch == '0) ||
                   (cfg_in.stride == '0) || (cfg_in.i_size == '0);
  assign accept  = (state_q == IDLE) && i_start && !i_clear && !cfg_bad;
  assign hs      = o_valid && i_ready;
  assign o_busy  = (state_q == RUN);

  // Counter stepping: ky innermost, then kx, then channel.
  always_comb begin
    k_m1    = cfg_q.k_size - PKG_DIM_WIDTH'(1);
    at_last = (c_q == cfg_q.ch - PKG_CH_WIDTH'(1)) && (kx_q == k_m1) && (ky_q == k_m1);
    c_n     = c_q;
    kx_n    = kx_q;
    ky_n    = ky_q + PKG_DIM_WIDTH'(1);
    if (ky_q == k_m1) begin
      ky_n = '0;
      kx_n = kx_q + PKG_DIM_WIDTH'(1);
      if (kx_q == k_m1) begin
        kx_n = '0;
        c_n  = c_q + PKG_CH_WIDTH'(1);
      end
    end
  end

  // The calculator always looks one element ahead so outputs can be registered:
  // from IDLE it sees the incoming config at tap 0, in RUN the stepped counters.
  always_comb begin
    sel_cfg = cfg_q;
    sel_c   = c_n;
    sel_kx  = kx_n;
    sel_ky  = ky_n;
    if (state_q == IDLE) begin
      sel_cfg = cfg_in;
      sel_c   = '0;
      sel_kx  = '0;
      sel_ky  = '0;
    end
    sel_last = (sel_c  == sel_cfg.ch - PKG_CH_WIDTH'(1)) &&
               (sel_kx == sel_cfg.k_size - PKG_DIM_WIDTH'(1)) &&
               (sel_ky == sel_cfg.k_size - PKG_DIM_WIDTH'(1));
  end

  conv_tap_addr_calc u_calc (
    .cfg  (sel_cfg),
    .c    (sel_c),
    .kx   (sel_kx),
    .ky   (sel_ky),
    .addr (calc_addr),
    .pad  (calc_pad)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (hs && at_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_clear) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      cfg_q     <= '0;
      c_q       <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      o_valid   <= 1'b0;
      o_addr    <= '0;
      o_pad     <= 1'b0;
      o_last    <= 1'b0;
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;
    end else if (i_clear) begin
      cfg_q     <= '0;
      c_q       <= '0;
      kx_q      <= '0;
      ky_q      <= '0;
      o_valid   <= 1'b0;
      o_addr    <= '0;
      o_pad     <= 1'b0;
      o_last    <= 1'b0;
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= (state_q == IDLE) && i_start && cfg_bad;
      o_done    <= 1'b0;
      if (accept) begin
        cfg_q   <= cfg_in;
        c_q     <= '0;
        kx_q    <= '0;
        ky_q    <= '0;
        o_valid <= 1'b1;
        o_addr  <= calc_addr;
        o_pad   <= calc_pad;
        o_last  <= sel_last;
      end else if (hs) begin
        if (at_last) begin
          c_q     <= '0;
          kx_q    <= '0;
          ky_q    <= '0;
          o_valid <= 1'b0;
          o_addr  <= '0;
          o_pad   <= 1'b0;
          o_last  <= 1'b0;
          o_done  <= 1'b1;
        end else begin
          c_q    <= c_n;
          kx_q   <= kx_n;
          ky_q   <= ky_n;
          o_addr <= calc_addr;
          o_pad  <= calc_pad;
          o_last <= sel_last;
        end
      end
    end
  end

endmodule

// File: doc/conv_window_addr_gen.md
Name: conv_window_addr_gen

Overview:
Multi-channel convolution window address generator, successor to the single-channel kernel walker in the router.
- Per output pixel (o_x, o_y), walks every kernel tap across every input channel and emits one input-buffer read address per tap.
- Adds configurable stride, symmetric zero-padding (pad taps flagged instead of addressed), a channel loop, and valid/ready back-pressure.
- Sits between the tile controller and the input buffer read port.

Parameters:
BUF_DEPTH, 1024, input buffer depth in words; ADDR_WIDTH = $clog2(BUF_DEPTH) (derived localparam)
DIM_WIDTH, 8, width of spatial fields (k_size, i_size, o_x, o_y, stride, pad)
CH_WIDTH, 6, width of channel count

Ports:
i_clk  in  1  clock
i_nrst  in  1  reset, asynchronous, active-low
i_start  in  1  start pulse; sampled only in IDLE
i_clear  in  1  synchronous abort, highest priority after reset
i_k_size  in  DIM_WIDTH  kernel side K (square kernel)
i_i_size  in  DIM_WIDTH  input plane side W (square plane, row-major)
i_ch  in  CH_WIDTH  channel count C
i_stride  in  DIM_WIDTH  stride S
i_pad  in  DIM_WIDTH  padding P
i_o_x, i_o_y  in  DIM_WIDTH  output row / column
i_start_addr  in  ADDR_WIDTH  tile base address
i_ch_stride  in  ADDR_WIDTH  words per channel plane
o_valid  out  1  o_addr / o_pad / o_last valid
i_ready  in  1  consumer accepts current element
o_addr  out  ADDR_WIDTH  read address (0 when o_pad)
o_pad  out  1  tap lies in padding; consumer inserts zero
o_last  out  1  final element of the window
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse after the last handshake
o_cfg_err  out  1  one-cycle pulse on rejected start

Behaviour:
- Reset (async) and i_clear: state IDLE, all counters 0, all outputs 0.
- States: IDLE, RUN, DONE.
- IDLE + i_start:
  - Latch all config inputs; inputs are ignored until the next IDLE.
  - If K==0, C==0, S==0 or W==0: pulse o_cfg_err, stay IDLE.
  - Otherwise go to RUN.
- Latency: first element has o_valid=1 in the cycle after i_start is accepted.
- Iteration order: channel c outermost (0..C-1), then kernel row kx (0..K-1), then kernel column ky innermost (0..K-1). Total K*K*C elements.
- Per tap, signed arithmetic with width DIM_WIDTH*2+2:
  - r = o_x*S + kx - P; col = o_y*S + ky - P.
  - Pad tap if r<0, r>=W, col<0 or col>=W: o_pad=1, o_addr=0.
  - Otherwise o_pad=0, o_addr = (start_addr + c*ch_stride + r*W + col) mod BUF_DEPTH. Wrap is silent; no error.
- Handshake:
  - The element advances only when o_valid && i_ready.
  - While o_valid && !i_ready, o_addr, o_pad and o_last hold stable.
  - With i_ready held high, throughput is 1 element per cycle, no bubbles.
- o_last=1 only on element (c=C-1, kx=K-1, ky=K-1).
- On the handshake of the last element: o_valid=0 next cycle, state DONE, o_done=1 for exactly one cycle, then IDLE.
- i_start in RUN or DONE: ignored.
- i_clear in any state, or in the same cycle as i_start: IDLE, outputs 0, o_done not pulsed.
- o_busy=1 in RUN only.

Decomposition:
- Package conv_ag_pkg: state enum (IDLE, RUN, DONE), signed intermediate width constant, config struct (k_size, i_size, ch, stride, pad, o_x, o_y, start_addr, ch_stride).
- Sub-module conv_tap_addr_calc: combinational. Takes latched config plus (c, kx, ky); returns {addr, pad}. Main block holds the FSM, nested counters and output registers.

Test Plan:
1. K=3, W=5, C=1, S=1, P=0, o=(1,1), base 0, ready=1 -> addrs 6,7,8,11,12,13,16,17,18; o_last on 18; o_done one cycle later.
2. K=3, W=4, P=1, S=1, o=(0,0) -> pad,pad,pad, pad,0,1, pad,4,5 (pad entries o_pad=1, o_addr=0).
3. K=2, W=4, C=2, ch_stride=16, base 100, o=(0,0) -> 100,101,104,105,116,117,120,121.
4. K=2, W=6, S=2, P=0, o=(1,2) -> 16,17,22,23; also base 1020 with BUF_DEPTH=1024, K=1, o=(0,5) -> addr 1 (wrap).
5. Scenario 1 with i_ready low for 3 cycles on element 4 -> o_addr=11 held stable; full sequence with no skip or duplicate; o_done delayed 3 cycles.
6. i_clear on element 5, and separately i_nrst low mid-run -> all outputs 0 next edge / immediately; no o_done. Start with K=0 -> o_cfg_err pulse, o_valid never rises.
